// File: rtl/cordic_lut_loader.sv
// Buffers a CORDIC coefficient table from a 16-bit host write stream,
// then replays it to CORDIC_16_pipe, pulses the pipe reset and enables it.
//
// Ports:
//   clk, reset (sync, active-low)
//   load_start               : pulse, begin a new table load
//   wr_valid/wr_data/wr_ready: host word stream, LS word of each entry first
//   index_wri/D/wen_o        : table write port to the pipe (wen_o active-low)
//   cordic_rst/cen_o         : pipe reset (active-high) and clock enable
//   busy/loaded              : loader status
module cordic_lut_loader #(
    parameter int DW      = 48,
    parameter int AW      = 6,
    parameter int WW      = 16,
    parameter int RST_CYC = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_start,
    input  logic          wr_valid,
    input  logic [WW-1:0] wr_data,
    output logic          wr_ready,
    output logic [AW-1:0] index_wri,
    output logic [DW-1:0] D,
    output logic          wen_o,
    output logic          cordic_rst,
    output logic          cen_o,
    output logic          busy,
    output logic          loaded
);

    localparam int NW    = DW / WW;
    localparam int DEPTH = 2 ** AW;
    localparam int WCW   = (NW > 1) ? $clog2(NW) : 1;
    localparam int SCW   = $clog2(RST_CYC + 1);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        STREAM,
        SETTLE,
        RUN
    } state_t;

    state_t         state, state_n;
    logic [WCW-1:0] wc, wc_n;
    logic [AW-1:0]  ec, ec_n;
    logic [AW-1:0]  k, k_n;
    logic [SCW-1:0] sc, sc_n;
    logic           mem_we;

    logic [DW-1:0]  mem [DEPTH];

    logic           wr_ready_n;
    logic [AW-1:0]  index_n;
    logic [DW-1:0]  d_n;
    logic           wen_n;
    logic           rst_n_out;
    logic           cen_n;
    logic           busy_n;
    logic           loaded_n;

    always_comb begin
        state_n = state;
        wc_n    = wc;
        ec_n    = ec;
        k_n     = k;
        sc_n    = sc;
        mem_we  = 1'b0;

        unique case (state)
            IDLE: ;
            FILL: begin
                if (wr_valid && wr_ready) begin
                    mem_we = 1'b1;
                    if (wc == WCW'(NW - 1)) begin
                        wc_n = '0;
                        ec_n = ec + 1'b1;
                        if (ec == {AW{1'b1}}) begin
                            state_n = STREAM;
                            k_n     = '0;
                        end
                    end else begin
                        wc_n = wc + 1'b1;
                    end
                end
            end
            STREAM: begin
                if (k == {AW{1'b1}}) begin
                    state_n = SETTLE;
                    sc_n    = '0;
                end else begin
                    k_n = k + 1'b1;
                end
            end
            SETTLE: begin
                if (sc == SCW'(RST_CYC - 1)) begin
                    state_n = RUN;
                end else begin
                    sc_n = sc + 1'b1;
                end
            end
            RUN: ;
            default: state_n = IDLE;
        endcase

        // A restart beats everything, including a word accepted this cycle.
        if (load_start) begin
            state_n = FILL;
            wc_n    = '0;
            ec_n    = '0;
            mem_we  = 1'b0;
        end

        // Outputs are computed from the next state so they register
        // together with it; the buffer read is asynchronous, so D lands
        // in the same cycle as its index.
        wr_ready_n = (state_n == FILL);
        wen_n      = (state_n != STREAM);
        index_n    = (state_n == STREAM) ? k_n : '0;
        d_n        = (state_n == STREAM) ? mem[k_n] : D;
        rst_n_out  = (state_n != RUN);
        cen_n      = (state_n == RUN);
        loaded_n   = (state_n == RUN);
        busy_n     = (state_n == FILL) || (state_n == STREAM) ||
                     (state_n == SETTLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            wc         <= '0;
            ec         <= '0;
            k          <= '0;
            sc         <= '0;
            wr_ready   <= 1'b0;
            index_wri  <= '0;
            D          <= '0;
            wen_o      <= 1'b1;
            cordic_rst <= 1'b1;
            cen_o      <= 1'b0;
            busy       <= 1'b0;
            loaded     <= 1'b0;
        end else begin
            state      <= state_n;
            wc         <= wc_n;
            ec         <= ec_n;
            k          <= k_n;
            sc         <= sc_n;
            wr_ready   <= wr_ready_n;
            index_wri  <= index_n;
            D          <= d_n;
            wen_o      <= wen_n;
            cordic_rst <= rst_n_out;
            cen_o      <= cen_n;
            busy       <= busy_n;
            loaded     <= loaded_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && mem_we) begin
            for (int i = 0; i < NW; i++) begin
                if (wc == WCW'(i)) begin
                    mem[ec][i*WW +: WW] <= wr_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_cordic_lut_loader.sv
// Scoreboard bench for cordic_lut_loader: stimulus pushes expected
// table writes, a monitor pops and compares each wen_o=0 cycle.
module tb_cordic_lut_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load_start = 1'b0;
    logic        wr_valid = 1'b0;
    logic [15:0] wr_data = '0;
    logic        wr_ready;
    logic [5:0]  index_wri;
    logic [47:0] D;
    logic        wen_o;
    logic        cordic_rst;
    logic        cen_o;
    logic        busy;
    logic        loaded;

    typedef struct packed {
        logic [5:0]  idx;
        logic [47:0] d;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    cordic_lut_loader dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .index_wri  (index_wri),
        .D          (D),
        .wen_o      (wen_o),
        .cordic_rst (cordic_rst),
        .cen_o      (cen_o),
        .busy       (busy),
        .loaded     (loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [47:0] entry(input int pat, input int n);
        logic [15:0] nn;
        logic [47:0] e;
        nn = 16'(n);
        e  = {16'hC000 + nn, 16'h8000 + nn, 16'h4000 + nn};
        return (pat == 0) ? e : ~e;
    endfunction

    function automatic logic [15:0] word(input int pat, input int w);
        logic [47:0] e;
        e = entry(pat, w / 3);
        return e[(w % 3)*16 +: 16];
    endfunction

    // Monitor: every table write cycle must match the next expected entry.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (wen_o === 1'b0) begin
                if (q.size() == 0) begin
                    chk("unexpected_write", {58'd0, index_wri}, 64'hFFFF);
                end else begin
                    e = q.pop_front();
                    chk("stream_index", {58'd0, index_wri}, {58'd0, e.idx});
                    chk("stream_D", {16'd0, D}, {16'd0, e.d});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    task automatic push_table(input int pat, input int cnt);
        for (int n = 0; n < cnt; n++) begin
            q.push_back('{idx: 6'(n), d: entry(pat, n)});
        end
    endtask

    task automatic send_words(input int pat, input int cnt,
                              input int max_gap);
        int budget;
        for (int w = 0; w < cnt; w++) begin
            if (max_gap > 0) begin
                repeat ($urandom_range(0, max_gap)) step();
            end
            wr_valid = 1'b1;
            wr_data  = word(pat, w);
            budget   = 0;
            while (!wr_ready && budget < 20) begin
                step();
                budget++;
            end
            if (budget >= 20) begin
                chk("wr_ready_timeout", 64'd0, 64'd1);
            end
            step();
            wr_valid = 1'b0;
        end
    endtask

    // Called right after the edge that accepted the last word.
    task automatic finish_load(input string tag);
        chk({tag, "_wr_ready_drop"}, {63'd0, wr_ready}, 64'd0);
        chk({tag, "_busy_stream"}, {63'd0, busy}, 64'd1);
        repeat (64) step();
        chk({tag, "_settle_wen"}, {63'd0, wen_o}, 64'd1);
        chk({tag, "_settle_idx"}, {58'd0, index_wri}, 64'd0);
        chk({tag, "_settle_rst1"}, {63'd0, cordic_rst}, 64'd1);
        chk({tag, "_settle_cen1"}, {63'd0, cen_o}, 64'd0);
        step();
        chk({tag, "_settle_rst2"}, {63'd0, cordic_rst}, 64'd1);
        chk({tag, "_settle_cen2"}, {63'd0, cen_o}, 64'd0);
        step();
        chk({tag, "_run_rst"}, {63'd0, cordic_rst}, 64'd0);
        chk({tag, "_run_cen"}, {63'd0, cen_o}, 64'd1);
        chk({tag, "_run_loaded"}, {63'd0, loaded}, 64'd1);
        chk({tag, "_run_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_queue_empty"}, 64'(q.size()), 64'd0);
    endtask

    initial begin
        // T1 reset
        repeat (3) step();
        chk("rst_wen", {63'd0, wen_o}, 64'd1);
        chk("rst_cordic_rst", {63'd0, cordic_rst}, 64'd1);
        chk("rst_cen", {63'd0, cen_o}, 64'd0);
        chk("rst_wr_ready", {63'd0, wr_ready}, 64'd0);
        chk("rst_loaded", {63'd0, loaded}, 64'd0);
        chk("rst_index", {58'd0, index_wri}, 64'd0);
        chk("rst_D", {16'd0, D}, 64'd0);
        reset = 1'b1;
        step();

        // T2 full back-to-back load
        pulse_start();
        chk("t2_fill_ready", {63'd0, wr_ready}, 64'd1);
        chk("t2_fill_busy", {63'd0, busy}, 64'd1);
        push_table(0, 64);
        send_words(0, 192, 0);
        finish_load("t2");

        // T3 throttled host; stray words in RUN are ignored
        wr_valid = 1'b1;
        wr_data  = 16'hBEEF;
        repeat (3) step();
        wr_valid = 1'b0;
        chk("t3_stray_ready", {63'd0, wr_ready}, 64'd0);
        chk("t3_stray_loaded", {63'd0, loaded}, 64'd1);
        pulse_start();
        push_table(0, 64);
        send_words(0, 192, 5);
        finish_load("t3");

        // T4 restart mid-fill, with a word colliding with the restart
        pulse_start();
        send_words(0, 100, 0);
        wr_valid   = 1'b1;
        wr_data    = 16'hDEAD;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        wr_valid   = 1'b0;
        chk("t4_restart_ready", {63'd0, wr_ready}, 64'd1);
        push_table(1, 64);
        send_words(1, 192, 0);
        finish_load("t4");

        // T5 reset during STREAM at k=20
        pulse_start();
        push_table(0, 21);
        send_words(0, 192, 0);
        repeat (20) step();
        chk("t5_k20_idx", {58'd0, index_wri}, 64'd20);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("t5_wen", {63'd0, wen_o}, 64'd1);
        chk("t5_loaded", {63'd0, loaded}, 64'd0);
        chk("t5_busy", {63'd0, busy}, 64'd0);
        chk("t5_cordic_rst", {63'd0, cordic_rst}, 64'd1);
        repeat (70) step();
        chk("t5_idle_ready", {63'd0, wr_ready}, 64'd0);
        chk("t5_queue_empty", 64'(q.size()), 64'd0);

        // T6 reload from RUN
        pulse_start();
        push_table(0, 64);
        send_words(0, 192, 0);
        finish_load("t6a");
        pulse_start();
        chk("t6_cen", {63'd0, cen_o}, 64'd0);
        chk("t6_cordic_rst", {63'd0, cordic_rst}, 64'd1);
        chk("t6_loaded", {63'd0, loaded}, 64'd0);
        chk("t6_busy", {63'd0, busy}, 64'd1);
        push_table(1, 64);
        send_words(1, 192, 0);
        finish_load("t6b");

        repeat (5) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
